// File: rtl/lane_p2s_serializer.sv
// Per-lane parallel-to-serial stage: one byte every 8 clk_32f cycles, shifted out MSB-first,
// preceded by a burst of COM training symbols after every reset.
module lane_p2s_serializer #(
    parameter logic [7:0]  IDLE_SYM   = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       byte_req,
    output logic       data_out,
    output logic       valid_out,
    output logic       synced
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned SC_W   = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT + 1) : 1;

    localparam logic [0:0] ST_SYNC   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [BYTE_W-1:0] shreg_q,    shreg_d;
    logic              vflag_q,    vflag_d;
    logic [SC_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic [0:0]        state_q,    state_d;

    logic              load_c;
    logic [BYTE_W-1:0] sym_c;
    logic              dflag_c;

    // A load edge is the one where the bit counter wraps back to zero.
    assign load_c   = (bit_cnt_q == CNT_W'(0));
    assign byte_req = load_c && !reset;

    assign data_out  = shreg_q[BYTE_W-1];
    assign valid_out = vflag_q;
    assign synced    = (state_q == ST_ACTIVE);

    // State register.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            vflag_q    <= 1'b0;
            sync_cnt_q <= '0;
            state_q    <= ST_SYNC;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            vflag_q    <= vflag_d;
            sync_cnt_q <= sync_cnt_d;
            state_q    <= state_d;
        end
    end

    // Symbol select, shift/load and training FSM.
    always_comb begin
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        shreg_d    = {shreg_q[BYTE_W-2:0], 1'b0};
        vflag_d    = vflag_q;
        sync_cnt_d = sync_cnt_q;
        state_d    = state_q;
        sym_c      = IDLE_SYM;
        dflag_c    = 1'b0;

        if ((state_q == ST_ACTIVE) && valid_in) begin
            sym_c   = data_in;
            dflag_c = 1'b1;
        end

        if (load_c) begin
            shreg_d = sym_c;
            vflag_d = dflag_c;
            // Leaving SYNC only after the last COM is loaded gives exactly SYNC_COUNT COMs.
            if (state_q == ST_SYNC) begin
                if (sync_cnt_q != SC_W'(SYNC_COUNT)) begin
                    sync_cnt_d = sync_cnt_q + SC_W'(1);
                end
                if (sync_cnt_q == SC_W'(SYNC_COUNT - 1)) begin
                    state_d = ST_ACTIVE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_p2s_serializer.sv
// Self-checking bench for lane_p2s_serializer: byte-slot vector tables, reset corner cases,
// and randomized traffic checked against a slot-level reference model.
module tb_lane_p2s_serializer;

    localparam logic [7:0]  IDLE = 8'hBC;
    localparam int unsigned SYNC = 4;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       byte_req;
    logic       data_out;
    logic       valid_out;
    logic       synced;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic [7:0] eb;
        logic       ev;
        logic       es;
    } slot_vec_t;

    slot_vec_t tab_a[9];
    slot_vec_t tab_b[5];

    lane_p2s_serializer #(.IDLE_SYM(IDLE), .SYNC_COUNT(SYNC)) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .byte_req (byte_req),
        .data_out (data_out),
        .valid_out(valid_out),
        .synced   (synced)
    );

    always #5 clk_32f = ~clk_32f;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Hold reset for n edges; outputs must be cleared and byte_req suppressed.
    task automatic do_reset(input int n, input logic [7:0] d, input logic v);
        for (int i = 0; i < n; i++) begin
            reset = 1'b1; data_in = d; valid_in = v;
            #1;
            chk("rst_byte_req", 8'(byte_req), 8'd0);
            @(posedge clk_32f);
            @(negedge clk_32f);
            chk("rst_data_out", 8'(data_out), 8'd0);
            chk("rst_valid_out", 8'(valid_out), 8'd0);
            chk("rst_synced", 8'(synced), 8'd0);
        end
        reset = 1'b0;
    endtask

    // One byte slot: table values at the byte_req cycle, garbage on the other 7 cycles.
    task automatic drive_slot(input string name, input slot_vec_t s);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                data_in = s.d; valid_in = s.v;
            end else begin
                data_in = 8'($urandom); valid_in = 1'($urandom);
            end
            #1;
            chk({name, "_byte_req"}, 8'(byte_req), (i == 0) ? 8'd1 : 8'd0);
            @(posedge clk_32f);
            @(negedge clk_32f);
            chk({name, "_data_out"}, 8'(data_out), 8'(s.eb[7-i]));
            chk({name, "_valid_out"}, 8'(valid_out), 8'(s.ev));
            chk({name, "_synced"}, 8'(synced), 8'(s.es));
        end
    endtask

    initial begin
        // Clean start, then nominal training and data traffic.
        tab_a[0] = '{8'h00, 1'b0, IDLE,  1'b0, 1'b0};
        tab_a[1] = '{8'h00, 1'b0, IDLE,  1'b0, 1'b0};
        tab_a[2] = '{8'h00, 1'b0, IDLE,  1'b0, 1'b0};
        tab_a[3] = '{8'h00, 1'b0, IDLE,  1'b0, 1'b1};
        tab_a[4] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1};
        tab_a[5] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
        tab_a[6] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1};
        tab_a[7] = '{8'hBC, 1'b1, 8'hBC, 1'b1, 1'b1};
        tab_a[8] = '{8'h55, 1'b0, IDLE,  1'b0, 1'b1};
        // A valid byte offered during training is dropped and never resurfaces.
        tab_b[0] = '{8'h3C, 1'b1, IDLE,  1'b0, 1'b0};
        tab_b[1] = '{8'h3C, 1'b1, IDLE,  1'b0, 1'b0};
        tab_b[2] = '{8'h12, 1'b0, IDLE,  1'b0, 1'b0};
        tab_b[3] = '{8'h3C, 1'b0, IDLE,  1'b0, 1'b1};
        tab_b[4] = '{8'h3C, 1'b0, IDLE,  1'b0, 1'b1};

        reset = 1'b1; data_in = 8'hFF; valid_in = 1'b1;
        @(negedge clk_32f);

        do_reset(3, 8'hFF, 1'b1);
        foreach (tab_a[k]) drive_slot($sformatf("tabA%0d", k), tab_a[k]);

        do_reset(2, 8'h3C, 1'b1);
        foreach (tab_b[k]) drive_slot($sformatf("tabB%0d", k), tab_b[k]);

        // Reset in the middle of a data byte aborts it and restarts training.
        do_reset(1, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) drive_slot($sformatf("mid_train%0d", k), tab_a[k]);
        begin
            logic [7:0] b;
            b = 8'hA5;
            for (int i = 0; i < 3; i++) begin
                data_in = (i == 0) ? b : 8'h00; valid_in = (i == 0);
                #1;
                chk("mid_byte_req", 8'(byte_req), (i == 0) ? 8'd1 : 8'd0);
                @(posedge clk_32f);
                @(negedge clk_32f);
                chk("mid_data_out", 8'(data_out), 8'(b[7-i]));
                chk("mid_valid_out", 8'(valid_out), 8'd1);
            end
        end
        do_reset(1, 8'hA5, 1'b1);
        for (int k = 0; k < 5; k++) drive_slot($sformatf("retrain%0d", k), tab_a[k]);

        // Randomized traffic against a slot-level reference model.
        begin
            int         m_edges;
            logic [7:0] m_byte;
            logic       m_flag;
            logic       m_sync;
            logic       r;
            logic [7:0] d;
            logic       v;
            logic       exp_do;
            int         slot;
            int         b;
            m_edges = 0; m_byte = 8'h00; m_flag = 1'b0; m_sync = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                r = (c == 0) || ($urandom_range(0, 149) == 0);
                d = ($urandom_range(0, 7) == 0) ? IDLE : 8'($urandom);
                v = 1'($urandom);
                reset = r; data_in = d; valid_in = v;
                #1;
                chk("rnd_byte_req", 8'(byte_req), 8'(!r && (m_edges % 8 == 0)));
                @(posedge clk_32f);
                if (r) begin
                    m_edges = 0; m_byte = 8'h00; m_flag = 1'b0; m_sync = 1'b0;
                    exp_do = 1'b0;
                end else begin
                    if (m_edges % 8 == 0) begin
                        slot = m_edges / 8;
                        if (slot < int'(SYNC)) begin
                            m_byte = IDLE; m_flag = 1'b0;
                        end else begin
                            m_byte = v ? d : IDLE; m_flag = v;
                        end
                        if (slot >= int'(SYNC) - 1) m_sync = 1'b1;
                    end
                    b = 7 - (m_edges % 8);
                    exp_do = m_byte[b];
                    m_edges++;
                end
                @(negedge clk_32f);
                chk("rnd_data_out", 8'(data_out), 8'(exp_do));
                chk("rnd_valid_out", 8'(valid_out), 8'(m_flag));
                chk("rnd_synced", 8'(synced), 8'(m_sync));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
